p2_frame_rx: RTL and testbench

- Receive-side link decoder for the two-board race.
- Pops bytes from the UART RX FIFO (the rd_uart/rx_empty/r_data side of uart_ff_buf) and hunts for a 3-byte frame: SYNC, PAYLOAD, CHECK.
- Validates each frame and presents the remote player's status flags and per-frame position delta to player2_position and the top-level status logic.
- Also provides a link-alive indication and a saturating error count for debug and cockpit display.

---
 rtl/p2_frame_rx_pkg.sv | 24 ++
 rtl/p2_frame_rx_if.sv | 11 +
 rtl/p2_frame_rx_link_timeout.sv | 38 +++
 rtl/p2_frame_rx.sv | 120 ++++++++++++
 tb/tb_p2_frame_rx.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/p2_frame_rx_pkg.sv
// Shared link definitions for the two-board race link: frame markers,
// payload bit layout and the receive FSM state encoding.
package p2_frame_rx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CHK_XOR   = 8'h5A;

  localparam int KEY_BIT   = 7;
  localparam int RST_BIT   = 6;
  localparam int START_BIT = 5;
  localparam int DPOS_MSB  = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } link_state_t;

  // A check byte is good when it equals the payload XOR-ed with CHK_XOR.
  function automatic logic check_ok(input logic [7:0] payload, input logic [7:0] chk);
    return chk == (payload ^ CHK_XOR);
  endfunction

endpackage

// File: rtl/p2_frame_rx_if.sv
// RX FIFO read port (first-word fall-through): head byte, empty flag, pop.
interface p2_frame_rx_if;

  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;

  modport master (output rx_empty, output r_data, input rd_uart);
  modport slave  (input rx_empty, input r_data, output rd_uart);

endinterface

// File: rtl/p2_frame_rx_link_timeout.sv
// Saturating cycle counter with synchronous clear. The expired flag looks at
// the next count so registered consumers drop in the same cycle the count
// reaches LIMIT.
module p2_frame_rx_link_timeout #(
  parameter int LIMIT = 6500000,
  parameter int W     = 23
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic expired
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (cnt_q != LIMIT_V)
      cnt_d = cnt_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign expired = (cnt_d == LIMIT_V);

endmodule

// File: rtl/p2_frame_rx.sv
// Receive-side link decoder: pops bytes from the RX FIFO, hunts for
// SYNC/PAYLOAD/CHECK frames and presents the remote player's status.
module p2_frame_rx
  import p2_frame_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 6500000,
  parameter int TIMEOUT_W      = 23
) (
  input  logic         clk,
  input  logic         rst,
  p2_frame_rx_if.slave rx,
  output logic [4:0]   d_position,
  output logic         start_status,
  output logic         rst_req,
  output logic         key_status,
  output logic         frame_valid,
  output logic         link_alive,
  output logic [7:0]   err_count
);

  link_state_t state_q;
  link_state_t state_d;
  logic [7:0]  payload_q;
  logic        pop;
  logic        load_payload;
  logic        accept;
  logic        reject;
  logic        expired;

  assign rx.rd_uart = pop;

  // FSM state register; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= HUNT;
    else
      state_q <= state_d;
  end

  // Next state, advancing only on cycles where a byte is popped.
  always_comb begin
    state_d = state_q;
    if (pop) begin
      case (state_q)
        HUNT:    if (rx.r_data == SYNC_BYTE) state_d = PAYLOAD;
        PAYLOAD: state_d = CHECK;
        CHECK: begin
          if (check_ok(payload_q, rx.r_data))
            state_d = HUNT;
          else if (rx.r_data == SYNC_BYTE)
            state_d = PAYLOAD;  // bad check byte that looks like SYNC restarts a frame
          else
            state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // FSM decode: pop strobe and per-byte frame events.
  always_comb begin
    pop          = ~rx.rx_empty;
    load_payload = pop && (state_q == PAYLOAD);
    accept       = pop && (state_q == CHECK) && check_ok(payload_q, rx.r_data);
    reject       = pop && (state_q == CHECK) && !check_ok(payload_q, rx.r_data);
  end

  // Payload byte held for the check comparison and the output update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      payload_q <= '0;
    else if (load_payload)
      payload_q <= rx.r_data;
  end

  // Frame outputs one cycle after the check pop; an accept beats a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_valid  <= 1'b0;
      d_position   <= '0;
      start_status <= 1'b0;
      rst_req      <= 1'b0;
      key_status   <= 1'b0;
      link_alive   <= 1'b0;
    end else begin
      frame_valid <= accept;
      d_position  <= accept ? payload_q[DPOS_MSB:0] : 5'd0;
      if (accept) begin
        start_status <= payload_q[START_BIT];
        rst_req      <= payload_q[RST_BIT];
        key_status   <= payload_q[KEY_BIT];
        link_alive   <= 1'b1;
      end else if (expired) begin
        start_status <= 1'b0;
        rst_req      <= 1'b0;
        key_status   <= 1'b0;
        link_alive   <= 1'b0;
      end
    end
  end

  // Rejected-frame counter, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (reject && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end

  p2_frame_rx_link_timeout #(
    .LIMIT (TIMEOUT_CYCLES),
    .W     (TIMEOUT_W)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (accept),
    .expired (expired)
  );

endmodule

// File: tb/tb_p2_frame_rx.sv
// Bench for p2_frame_rx: directed frame scenarios plus a random byte stream,
// checked against a queue-based frame model.
module tb_p2_frame_rx;

  localparam int T = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] d_position;
  logic       start_status, rst_req, key_status, frame_valid, link_alive;
  logic [7:0] err_count;

  p2_frame_rx_if bus ();

  p2_frame_rx #(.TIMEOUT_CYCLES(T), .TIMEOUT_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx           (bus),
    .d_position   (d_position),
    .start_status (start_status),
    .rst_req      (rst_req),
    .key_status   (key_status),
    .frame_valid  (frame_valid),
    .link_alive   (link_alive),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO contents and reference model state
  logic [7:0] q[$];
  logic [7:0] win[$];
  logic       stall = 1'b0;
  logic       e_fv, e_start, e_rstq, e_key, e_alive;
  logic [4:0] e_dpos;
  logic [7:0] e_err;
  int         age;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    win.delete();
    e_fv = 0; e_dpos = 0; e_start = 0; e_rstq = 0; e_key = 0; e_alive = 0;
    e_err = 0; age = 0;
  endtask

  // Frame rules on the popped-byte stream: a window collects SYNC and PAYLOAD,
  // the third byte decides accept or reject.
  task automatic model_step(input logic popped, input logic [7:0] b);
    logic acc, rej;
    logic [7:0] pay;
    acc = 0; rej = 0; pay = 0;
    if (popped) begin
      if (win.size() == 0) begin
        if (b == 8'hA5) win.push_back(b);
      end else if (win.size() == 1) begin
        win.push_back(b);
      end else begin
        pay = win[1];
        if (b == (pay ^ 8'h5A)) acc = 1; else rej = 1;
        win.delete();
        if (rej && b == 8'hA5) win.push_back(b);
      end
    end
    if (acc) begin
      e_fv = 1; e_dpos = pay[4:0];
      e_key = pay[7]; e_rstq = pay[6]; e_start = pay[5];
      e_alive = 1; age = 0;
    end else begin
      e_fv = 0; e_dpos = 0;
      if (age < T) age++;
      if (age == T) begin
        e_alive = 0; e_key = 0; e_rstq = 0; e_start = 0;
      end
    end
    if (rej && e_err != 8'hFF) e_err++;
  endtask

  task automatic drive_bus();
    bus.rx_empty = stall || (q.size() == 0);
    bus.r_data   = (q.size() != 0) ? q[0] : 8'h00;
  endtask

  task automatic compare_all();
    chk("frame_valid",  {7'd0, frame_valid},  {7'd0, e_fv});
    chk("d_position",   {3'd0, d_position},   {3'd0, e_dpos});
    chk("start_status", {7'd0, start_status}, {7'd0, e_start});
    chk("rst_req",      {7'd0, rst_req},      {7'd0, e_rstq});
    chk("key_status",   {7'd0, key_status},   {7'd0, e_key});
    chk("link_alive",   {7'd0, link_alive},   {7'd0, e_alive});
    chk("err_count",    err_count,            e_err);
  endtask

  // One clock: consume the head byte if offered, compare, drive next cycle.
  task automatic tick();
    logic popped;
    logic [7:0] b;
    popped = !bus.rx_empty;
    b = bus.r_data;
    @(posedge clk);
    if (popped) void'(q.pop_front());
    model_step(popped, b);
    #1;
    compare_all();
    drive_bus();
    #1;
    chk("rd_uart", {7'd0, bus.rd_uart}, {7'd0, !bus.rx_empty});
  endtask

  task automatic run_until_empty();
    int n;
    n = 0;
    drive_bus();
    while (q.size() > 0 && n < 3000) begin
      tick();
      n++;
    end
    chk("fifo_drained", {7'd0, q.size() == 0}, 8'd1);
  endtask

  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    q.push_back(a); q.push_back(b); q.push_back(c);
  endtask

  initial begin
    logic [7:0] p, c, j, err_before;
    int r;
    model_reset();
    drive_bus();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    compare_all();
    chk("rd_uart_empty", {7'd0, bus.rd_uart}, 8'd0);

    // Plain frame, payload 2B
    push3(8'hA5, 8'h2B, 8'h71);
    run_until_empty();
    chk("t1_fv", {7'd0, frame_valid}, 8'd1);
    chk("t1_dpos", {3'd0, d_position}, 8'h0B);
    chk("t1_start", {7'd0, start_status}, 8'd1);
    chk("t1_rstq", {7'd0, rst_req}, 8'd0);
    chk("t1_key", {7'd0, key_status}, 8'd0);
    chk("t1_alive", {7'd0, link_alive}, 8'd1);
    tick();
    chk("t1_dpos_after", {3'd0, d_position}, 8'd0);

    // Leading junk, then payload E0
    q.push_back(8'h00); q.push_back(8'h13);
    push3(8'hA5, 8'hE0, 8'hBA);
    run_until_empty();
    chk("t2_err", err_count, 8'd0);
    chk("t2_key", {7'd0, key_status}, 8'd1);
    chk("t2_rstq", {7'd0, rst_req}, 8'd1);
    chk("t2_start", {7'd0, start_status}, 8'd1);
    chk("t2_fv", {7'd0, frame_valid}, 8'd1);

    // Bad check followed by a good frame
    push3(8'hA5, 8'h10, 8'h00);
    run_until_empty();
    chk("t3_err", err_count, 8'd1);
    push3(8'hA5, 8'h10, 8'h4A);
    run_until_empty();
    chk("t3_dpos", {3'd0, d_position}, 8'h10);

    // Bad check byte A5 resyncs into the next frame
    err_before = err_count;
    push3(8'hA5, 8'h10, 8'hA5);
    q.push_back(8'h03); q.push_back(8'h59);
    run_until_empty();
    chk("t4_err_delta", err_count - err_before, 8'd1);
    chk("t4_dpos", {3'd0, d_position}, 8'd3);

    // Idle link times out exactly T cycles after frame_valid
    repeat (T - 1) tick();
    chk("tmo_alive_before", {7'd0, link_alive}, 8'd1);
    tick();
    chk("tmo_alive", {7'd0, link_alive}, 8'd0);
    chk("tmo_flags", {5'd0, start_status, rst_req, key_status}, 8'd0);
    push3(8'hA5, 8'h21, 8'h7B);
    run_until_empty();
    chk("tmo_recover", {7'd0, link_alive}, 8'd1);

    // Random stream of good, bad and junk bytes with FIFO stalls
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      p = 8'($urandom_range(0, 255));
      if (r <= 5) begin
        push3(8'hA5, p, p ^ 8'h5A);
      end else if (r <= 7) begin
        c = p ^ 8'h5A ^ 8'($urandom_range(1, 255));
        push3(8'hA5, p, c);
      end else begin
        j = 8'($urandom_range(0, 255));
        if (j == 8'hA5) j = 8'h00;
        q.push_back(j);
      end
    end
    drive_bus();
    for (int n = 0; n < 3000 && q.size() > 0; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    stall = 1'b0;
    chk("rand_drained", {7'd0, q.size() == 0}, 8'd1);
    repeat (4) tick();

    // Async reset between PAYLOAD and CHECK pops
    push3(8'hA5, 8'hE3, 8'hB9);
    q.push_back(8'hA5); q.push_back(8'h10);
    run_until_empty();
    chk("pre_rst_key", {7'd0, key_status}, 8'd1);
    stall = 1'b1;
    drive_bus();
    #2 rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    #2 rst = 1'b0;
    stall = 1'b0;
    q.push_back(8'h4A);
    run_until_empty();
    chk("rst_no_frame", {7'd0, frame_valid}, 8'd0);
    repeat (3) tick();

    // err_count saturates at 255
    for (int i = 0; i < 260; i++) push3(8'hA5, 8'h00, 8'h00);
    run_until_empty();
    chk("err_sat", err_count, 8'hFF);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
